// File: rtl/rx_core_cfg_pkg.sv
// Shared types, register map and helpers for the receive-core control plane.
package rx_core_cfg_pkg;

  // Commit / apply / ramp sequencing states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_APPLY      = 2'd2,
    ST_RAMP       = 2'd3
  } state_e;

  // Register map: three global registers, then (phase_inc, gain) pairs per DUC
  localparam int ADDR_DDC         = 0;
  localparam int ADDR_DEMIX_GAIN  = 1;
  localparam int ADDR_DEMIX_PHASE = 2;
  localparam int ADDR_DUC_BASE    = 3;

  // Address width needed to cover every mapped register
  function automatic int addr_w(input int n_duc);
    return $clog2(3 + 2 * n_duc);
  endfunction

  // True for register indices that hold a DUC gain (stored GAIN_W wide)
  function automatic bit is_gain_addr(input int idx);
    return (idx > ADDR_DUC_BASE) && (((idx - ADDR_DUC_BASE) % 2) == 1);
  endfunction

endpackage

// File: rtl/rx_core_cfg_gain_ramp.sv
// One DUC gain channel: moves the gain one LSB toward its target per step pulse.
module rx_core_cfg_gain_ramp
  import rx_core_cfg_pkg::*;
#(
  parameter int GAIN_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [GAIN_W-1:0] i_target,
  input  logic              i_step,
  output logic [GAIN_W-1:0] o_gain,
  output logic              o_done
);

  logic [GAIN_W-1:0] r_gain;

  // Unsigned single-LSB step; equality stops it, so it can never overshoot or wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gain <= '0;
    end else if (i_step) begin
      if (r_gain < i_target) begin
        r_gain <= r_gain + GAIN_W'(1);
      end else if (r_gain > i_target) begin
        r_gain <= r_gain - GAIN_W'(1);
      end else begin
        r_gain <= r_gain;
      end
    end
  end

  assign o_gain = r_gain;
  assign o_done = (r_gain == i_target);

endmodule

// File: rtl/rx_core_cfg.sv
// Receive-core control plane: shadow registers behind a write port, applied to
// the datapath atomically on a frame boundary, with DUC gains ramped per LSB.
module rx_core_cfg
  import rx_core_cfg_pkg::*;
#(
  parameter  int N_DUC     = 3,
  parameter  int PHASE_W   = 16,
  parameter  int GAIN_W    = 8,
  parameter  int FRAME_LEN = 4,
  parameter  int RAMP_DIV  = 16,
  localparam int ADDR_W    = addr_w(N_DUC)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [PHASE_W-1:0]       wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [PHASE_W-1:0]       rd_data,
  input  logic                     commit,
  output logic                     busy,
  output logic                     frame_start,
  output logic [PHASE_W-1:0]       ddc_phase_inc,
  output logic [PHASE_W-1:0]       demix_phase_inc,
  output logic [PHASE_W-1:0]       demix_gain,
  output logic [N_DUC*PHASE_W-1:0] duc_phase_inc,
  output logic [N_DUC*GAIN_W-1:0]  duc_gain
);

  localparam int N_REG = 3 + 2 * N_DUC;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(RAMP_DIV - 1);

  logic [PHASE_W-1:0]       r_shadow [N_REG];
  logic [PHASE_W-1:0]       r_rd_data;
  logic [PHASE_W-1:0]       w_rd_next;
  logic [CNT_W-1:0]         r_frame_cnt;
  logic                     r_frame_start;
  logic [DIV_W-1:0]         r_div;
  state_e                   r_state;
  state_e                   w_state_next;
  logic                     r_pending;
  logic                     r_busy;
  logic [PHASE_W-1:0]       r_ddc;
  logic [PHASE_W-1:0]       r_demix_phase;
  logic [PHASE_W-1:0]       r_demix_gain;
  logic [N_DUC*PHASE_W-1:0] r_duc_phase;
  logic [N_DUC*GAIN_W-1:0]  r_gain_tgt;
  logic [N_DUC*GAIN_W-1:0]  w_gain;
  logic [N_DUC-1:0]         w_ch_done;
  logic                     w_all_done;
  logic                     w_frame_last;
  logic                     w_take_commit;
  logic                     w_load;
  logic                     w_div_run;
  logic                     w_div_wrap;
  logic                     w_step;

  // Shadow register file: writes are accepted in every state; gains keep only the low bits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REG; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < N_REG; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          if (is_gain_addr(i)) begin
            r_shadow[i] <= PHASE_W'(wr_data[GAIN_W-1:0]);
          end else begin
            r_shadow[i] <= wr_data;
          end
        end
      end
    end
  end

  // Readback mux; unmapped addresses fall through to zero
  always_comb begin
    w_rd_next = '0;
    for (int i = 0; i < N_REG; i++) begin
      w_rd_next = (rd_addr == ADDR_W'(i)) ? r_shadow[i] : w_rd_next;
    end
  end

  // Readback register, one cycle behind rd_addr
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  assign w_frame_last = (r_frame_cnt == FRAME_LAST);

  // Free-running frame counter; frame_start is registered alongside the count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b1;
    end else if (w_frame_last) begin
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b1;
    end else begin
      r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
      r_frame_start <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; RAMP exits as soon as every channel sits on its target
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (commit || r_pending) begin
          w_state_next = ST_WAIT_FRAME;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_FRAME: begin
        if (w_frame_last) begin
          w_state_next = ST_APPLY;
        end else begin
          w_state_next = ST_WAIT_FRAME;
        end
      end
      ST_APPLY: begin
        w_state_next = ST_RAMP;
      end
      ST_RAMP: begin
        if (w_all_done) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RAMP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM decoded controls: the active load happens on the edge entering APPLY so the
  // new values are visible in the frame_cnt == 0 cycle; the divider runs from APPLY
  always_comb begin
    w_take_commit = (r_state == ST_IDLE) && (commit || r_pending);
    w_load        = (r_state == ST_WAIT_FRAME) && w_frame_last;
    w_div_run     = (r_state == ST_APPLY) || (r_state == ST_RAMP);
    w_div_wrap    = (r_div == DIV_LAST);
    w_step        = w_div_run && w_div_wrap;
  end

  // Pending flag: commits seen while busy collapse into a single deferred request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_take_commit) begin
      r_pending <= 1'b0;
    end else if (commit) begin
      r_pending <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Ramp divider, held at zero outside APPLY/RAMP so every ramp starts aligned
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (!w_div_run || w_div_wrap) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Busy tracks the next state so it rises the cycle after an accepted commit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
    end
  end

  // Active outputs and gain targets; a same-edge shadow write is not seen here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ddc         <= '0;
      r_demix_gain  <= '0;
      r_demix_phase <= '0;
      r_duc_phase   <= '0;
      r_gain_tgt    <= '0;
    end else if (w_load) begin
      r_ddc         <= r_shadow[ADDR_DDC];
      r_demix_gain  <= r_shadow[ADDR_DEMIX_GAIN];
      r_demix_phase <= r_shadow[ADDR_DEMIX_PHASE];
      for (int k = 0; k < N_DUC; k++) begin
        r_duc_phase[k*PHASE_W +: PHASE_W] <= r_shadow[ADDR_DUC_BASE + 2*k];
        r_gain_tgt[k*GAIN_W +: GAIN_W]    <= r_shadow[ADDR_DUC_BASE + 2*k + 1][GAIN_W-1:0];
      end
    end
  end

  for (genvar k = 0; k < N_DUC; k++) begin : g_duc
    rx_core_cfg_gain_ramp #(
      .GAIN_W (GAIN_W)
    ) u_gain_ramp (
      .clock    (clock),
      .reset    (reset),
      .i_target (r_gain_tgt[k*GAIN_W +: GAIN_W]),
      .i_step   (w_step),
      .o_gain   (w_gain[k*GAIN_W +: GAIN_W]),
      .o_done   (w_ch_done[k])
    );
  end

  assign w_all_done      = &w_ch_done;
  assign rd_data         = r_rd_data;
  assign busy            = r_busy;
  assign frame_start     = r_frame_start;
  assign ddc_phase_inc   = r_ddc;
  assign demix_phase_inc = r_demix_phase;
  assign demix_gain      = r_demix_gain;
  assign duc_phase_inc   = r_duc_phase;
  assign duc_gain        = w_gain;

endmodule

// File: doc/rx_core_cfg.md
# rx_core_cfg

Parametrised control-plane block for the receive core. It holds the DDC, demixer and per-channel DUC settings behind a register-write port. It applies them to the datapath atomically on a frame boundary, so that all DUC phase increments change on the same sample frame. It ramps DUC gains one LSB at a time toward their new targets to avoid output steps. It sits between the PS register bank and `rx_core`, and replaces the single shared DUC phase increment with N independent channels.

## Interface
- `N_DUC`, 3, number of DUC/DAC channels (1..8)
- `PHASE_W`, 16, phase-increment width; also write/read data width
- `GAIN_W`, 8, DUC gain width (unsigned, ≤ PHASE_W)
- `FRAME_LEN`, 4, clock cycles per sample frame (down-conversion ratio)
- `RAMP_DIV`, 16, clock cycles per gain ramp step (≥ 1)
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `wr_en`  in  1  write strobe, one write per cycle
- `wr_addr`  in  ADDR_W = clog2(3+2·N_DUC)  register address
- `wr_data`  in  PHASE_W  write data; gain registers use the low GAIN_W bits
- `rd_addr`  in  ADDR_W  readback address
- `rd_data`  out  PHASE_W  shadow register readback, zero-extended
- `commit`  in  1  single-cycle request to apply the shadow registers
- `busy`  out  1  high from the cycle after an accepted commit until the ramp finishes
- `frame_start`  out  1  high when the frame counter is 0
- `ddc_phase_inc`, `demix_phase_inc`, `demix_gain`  out  PHASE_W each  active values
- `duc_phase_inc`  out  N_DUC·PHASE_W  channel k at bits [k·PHASE_W +: PHASE_W]
- `duc_gain`  out  N_DUC·GAIN_W  channel k at bits [k·GAIN_W +: GAIN_W]

## Operation
- Register map: 0 ddc_phase_inc, 1 demix_gain, 2 demix_phase_inc, 3+2k duc k phase_inc, 4+2k duc k gain. Writes to unmapped addresses are ignored; reads of them return 0.
- Writes update shadow registers only and are accepted in any state.
- Frame counter: free-running 0..FRAME_LEN-1, wraps to 0.
- FSM states: IDLE, WAIT_FRAME, APPLY, RAMP.
  - IDLE: on `commit`, or with the pending flag set, go to WAIT_FRAME and clear the pending flag.
  - WAIT_FRAME: when frame_cnt == FRAME_LEN-1, go to APPLY.
  - APPLY (one cycle, frame_cnt == 0): copy all phase-increment and demix shadows to the active outputs; latch the shadow DUC gains as gain targets; go to RAMP.
  - RAMP: a divider counts 0..RAMP_DIV-1. On each wrap, every channel whose gain ≠ target steps ±1 toward it. Exit to IDLE in the cycle where all gains equal their targets, checked every cycle, including the first RAMP cycle.
- `commit` while busy sets the pending flag. Multiple commits collapse into one. Shadow contents are sampled at APPLY, not at commit.
- A write to a shadow register in the same cycle as APPLY: APPLY uses the old shadow value; the new value lands in the shadow.
- Gain arithmetic is unsigned with no wrap. Steps never overshoot the target.

## Timing
- Reset: all active outputs 0, gains and targets 0, `busy` 0, `rd_data` 0, pending 0, frame_cnt 0, divider 0, FSM IDLE.
- `rd_data` is registered with 1-cycle latency.
- Commit in cycle t → `busy` = 1 at t+1.
- Active phase values change on the clock edge ending the frame_cnt == FRAME_LEN-1 cycle. They are visible when `frame_start` = 1.
- Worst-case commit to apply latency is FRAME_LEN+1 cycles.
- A gain change of Δ completes Δ·RAMP_DIV cycles after APPLY.
- `busy` falls in the cycle after the last gain equals its target, or 1 cycle after APPLY if no gain changes.
- Reset asserted mid-ramp aborts immediately to the reset state. Shadows are also cleared.

## Structure
- Package `rx_core_cfg_pkg`: state enum, register address constants (ADDR_DDC, ADDR_DEMIX_GAIN, ADDR_DEMIX_PHASE, ADDR_DUC_BASE), and the ADDR_W function.
- Sub-module `gain_ramp`, one per DUC channel (generate loop): target in, step enable in, gain out, done out.

## Test plan
- Reset, then read all addresses → `rd_data` = 0 and all outputs 0; `frame_start` pulses every 4 cycles.
- Write duc0..2 phase_inc = 0x1000/0x2000/0x3000, commit at frame_cnt = 1 → all three outputs change together when frame_cnt reaches 0; `busy` = 1 from the next cycle until 1 cycle after APPLY.
- Write gain1 = 5 from 0, RAMP_DIV = 16, commit → duc1 gain steps 1,2,3,4,5 at 16-cycle intervals; `busy` clears after the 5th step.
- Gain ramps down from 10 to 7 while another channel ramps up from 0 to 2 → both step together; `busy` stays high until the 3rd step.
- Commit twice during a ramp and rewrite shadows → exactly one further APPLY, using the latest shadow values.
- Assert reset mid-ramp at gain 3 of 8 → all outputs 0 on the next edge; FSM IDLE; a subsequent commit behaves as from cold start.
